jtag_sb_regs: RTL

JTAG_SB_REGS -- requirements
Module: jtag_sb_regs

---
 rtl/jtag_sb_regs.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/jtag_sb_regs.sv
// jtag_sb_regs: DMI-side system bus access registers (sbcs, sbaddress0, sbdata0).
// Ports: DMI req/resp handshake in, SBA engine control/pulses out, SBA status in.
module jtag_sb_regs #(
  parameter logic [6:0] SBCS_ADDR    = 7'h38,
  parameter logic [6:0] SBADDR0_ADDR = 7'h39,
  parameter logic [6:0] SBDATA0_ADDR = 7'h3C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_addr_i,
  input  logic [1:0]  dmi_op_i,
  input  logic [31:0] dmi_wdata_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_rdata_o,
  output logic [31:0] sbaddress_o,
  output logic        sbaddress_write_valid_o,
  output logic        sbreadonaddr_o,
  output logic        sbautoincrement_o,
  output logic [2:0]  sbaccess_o,
  output logic        sbreadondata_o,
  output logic [31:0] sbdata_o,
  output logic        sbdata_read_valid_o,
  output logic        sbdata_write_valid_o,
  input  logic [31:0] sbaddress_i,
  input  logic [31:0] sbdata_i,
  input  logic        sbdata_valid_i,
  input  logic        sbbusy_i,
  input  logic [2:0]  sberror_i
);

  logic        resp_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  err_q;
  logic        busyerr_q;
  logic        rdonaddr_q;
  logic        autoinc_q;
  logic        rdondata_q;
  logic [2:0]  access_q;
  logic        aw_q;
  logic        dw_q;
  logic        dr_q;

  logic        accept;
  logic        is_rd;
  logic        is_wr;
  logic        sel_cs;
  logic        sel_ad;
  logic        sel_dt;
  logic        blocked;
  logic        wr_cs;
  logic        wr_ad;
  logic        wr_dt;
  logic        rd_dt;
  logic        busy_viol;
  logic [31:0] sbcs;
  logic [31:0] rdata_d;

  assign accept  = dmi_req_valid_i & ~resp_q;
  assign is_rd   = accept & (dmi_op_i == 2'd1);
  assign is_wr   = accept & (dmi_op_i == 2'd2);
  assign sel_cs  = dmi_addr_i == SBCS_ADDR;
  assign sel_ad  = dmi_addr_i == SBADDR0_ADDR;
  assign sel_dt  = dmi_addr_i == SBDATA0_ADDR;
  assign blocked = sbbusy_i | busyerr_q | (|err_q);
  assign wr_cs   = is_wr & sel_cs;
  assign wr_ad   = is_wr & sel_ad;
  assign wr_dt   = is_wr & sel_dt;
  assign rd_dt   = is_rd & sel_dt;

  // Touching address/data while the engine runs is a busy error.
  assign busy_viol = sbbusy_i & (wr_ad | wr_dt | rd_dt);

  assign sbcs = {3'd1, 6'd0, busyerr_q, sbbusy_i,
                 rdonaddr_q, access_q, autoinc_q,
                 rdondata_q, err_q, 7'd32, 5'b00111};

  always_comb begin
    rdata_d = '0;
    if (is_rd) begin
      unique case (1'b1)
        sel_cs:  rdata_d = sbcs;
        sel_ad:  rdata_d = addr_q;
        sel_dt:  rdata_d = data_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= '0;
      busyerr_q  <= 1'b0;
      rdonaddr_q <= 1'b0;
      autoinc_q  <= 1'b0;
      rdondata_q <= 1'b0;
      access_q   <= 3'd2;
      aw_q       <= 1'b0;
      dw_q       <= 1'b0;
      dr_q       <= 1'b0;
    end else begin
      if (accept) begin
        resp_q  <= 1'b1;
        rdata_q <= rdata_d;
      end else if (dmi_resp_ready_i) begin
        resp_q  <= 1'b0;
      end

      // Engine owns the address while busy (autoincrement tracking).
      if (sbbusy_i)   addr_q <= sbaddress_i;
      else if (wr_ad) addr_q <= dmi_wdata_i;

      if (sbdata_valid_i)         data_q <= sbdata_i;
      else if (wr_dt & ~sbbusy_i) data_q <= dmi_wdata_i;

      // Clear first, then OR in new errors so hardware wins.
      err_q <= (wr_cs ? (err_q & ~dmi_wdata_i[14:12]) : err_q)
               | sberror_i;

      if (busy_viol)                    busyerr_q <= 1'b1;
      else if (wr_cs & dmi_wdata_i[22]) busyerr_q <= 1'b0;

      if (wr_cs) begin
        rdonaddr_q <= dmi_wdata_i[20];
        access_q   <= dmi_wdata_i[19:17];
        autoinc_q  <= dmi_wdata_i[16];
        rdondata_q <= dmi_wdata_i[15];
      end

      aw_q <= wr_ad & ~blocked;
      dw_q <= wr_dt & ~blocked;
      dr_q <= rd_dt & ~blocked;
    end
  end

  assign dmi_req_ready_o         = ~resp_q;
  assign dmi_resp_valid_o        = resp_q;
  assign dmi_rdata_o             = rdata_q;
  assign sbaddress_o             = addr_q;
  assign sbdata_o                = data_q;
  assign sbreadonaddr_o          = rdonaddr_q;
  assign sbautoincrement_o       = autoinc_q;
  assign sbaccess_o              = access_q;
  assign sbreadondata_o          = rdondata_q;
  assign sbaddress_write_valid_o = aw_q;
  assign sbdata_write_valid_o    = dw_q;
  assign sbdata_read_valid_o     = dr_q;

endmodule
